// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix in a final cycle.
module sm_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, pneg_q, pneg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH:0] sum, trial, diff;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rmd;
  logic a_neg, b_neg;
  always_comb begin
    a_neg   = oper[0] & srcA[WIDTH-1];
    b_neg   = oper[0] & srcB[WIDTH-1];
    a_mag   = a_neg ? -srcA : srcA;
    b_mag   = b_neg ? -srcB : srcB;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    trial   = {rem_q, acc_q[WIDTH-1]};
    diff    = trial - {1'b0, b_q};
    prod    = pneg_q ? -acc_q : acc_q;
    quo     = pneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd     = rneg_q ? -rem_q : rem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pneg_d  = pneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = oper[1];
          pneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (srcB == '0);
          a_d     = a_mag;
          b_d     = b_mag;
          rem_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, oper[1] ? a_mag : b_mag};
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
        end else begin
          hi_d = mthi ? srcA : hi_q;
          lo_d = mtlo ? srcA : lo_q;
        end
      end
      CALC: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? FIX : CALC;
        // diff[WIDTH] is the borrow: set when the trial remainder is below the divisor
        rem_d   = div_q ? (diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]) : rem_q;
        acc_d   = div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]}
                : acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      end
      FIX: begin
        // with a zero divisor the remainder path reproduces the dividend, so only lo is forced
        hi_d    = div_q ? rmd : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      pneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pneg_q  <= pneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: randomized and directed checks of sm_muldiv against a plain-arithmetic model.
module tb_sm_muldiv;
  logic clk = 1'b0;
  logic rst_n, start, mthi, mtlo;
  logic [1:0] oper;
  logic [31:0] srcA, srcB;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int passes = 0;

  sm_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd0) res = {32'h0, a} * {32'h0, b};
    else if (op == 2'd1) res = sa * sb;
    else if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
    else if (op == 2'd2) res = {a % b, a / b};
    else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Starts an operation in the current cycle, scrambles inputs afterwards, waits for done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcy);
    @(negedge clk);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; oper = 2'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 0; bcy = 0;
    while (!done && lat < 200) begin
      if (busy) bcy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
    checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else passes++;
    checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else passes++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0001_0000, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [7] = '{32'd5, 32'hFFFF_FFFF, 32'h0001_0000, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'h0};
    logic [63:0] exp;
    int lat, bcy;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], lat, bcy);
      exp = model(ops[i], as[i], bs[i]);
      checks++; if (lat !== 33) $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); else passes++;
      checks++; if (bcy !== 33) $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bcy); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, busy); else passes++;
      checks++; if (hi !== exp[63:32]) $display("FAIL dir%0d_hi: got %h expected %h", i, hi, exp[63:32]); else passes++;
      checks++; if (lo !== exp[31:0]) $display("FAIL dir%0d_lo: got %h expected %h", i, lo, exp[31:0]); else passes++;
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done); else passes++;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat, bcy;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = rnd_val(); b = rnd_val();
      do_op(op, a, b, lat, bcy);
      exp = model(op, a, b);
      checks++; if (lat !== 33) $display("FAIL rnd%0d_latency: got %0d expected 33", i, lat); else passes++;
      checks++;
      if ({hi, lo} !== exp) $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, hi, lo, exp[63:32], exp[31:0]);
      else passes++;
    end
  endtask

  task automatic test_moves();
    logic [63:0] exp;
    int lat, bcy, waited;
    @(negedge clk); mthi = 1'b1; srcA = 32'h1234_5678;
    @(posedge clk); #1; mthi = 1'b0;
    checks++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi: got %h expected 12345678", hi); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL mthi_done: got %b expected 0", done); else passes++;
    @(negedge clk); mtlo = 1'b1; srcA = 32'h9ABC_DEF0;
    @(posedge clk); #1; mtlo = 1'b0;
    checks++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo_lo: got %h expected 9abcdef0", lo); else passes++;
    checks++; if (hi !== 32'h1234_5678) $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); else passes++;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; srcA = 32'h0BAD_F00D;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h0BAD_F00D}}) $display("FAIL mthi_mtlo_both: got %h_%h expected 0badf00d_0badf00d", hi, lo); else passes++;
    // mthi during a busy MULTU must be ignored; hi/lo hold until done
    @(negedge clk); start = 1'b1; oper = 2'd0; srcA = 32'hDEAD_BEEF; srcB = 32'h0000_1234;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; srcA = 32'h5555_5555;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h0BAD_F00D}}) $display("FAIL hold_during_calc: got %h_%h expected 0badf00d_0badf00d", hi, lo); else passes++;
    waited = 0;
    while (!done && waited < 200) begin @(posedge clk); #1; waited++; end
    exp = model(2'd0, 32'hDEAD_BEEF, 32'h0000_1234);
    checks++; if ({hi, lo} !== exp) $display("FAIL mthi_busy_ignored: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]); else passes++;
    // start together with mtlo: operation wins
    @(negedge clk); mtlo = 1'b1;
    do_op(2'd0, 32'h11, 32'h3, lat, bcy);
    mtlo = 1'b0;
    checks++; if ({hi, lo} !== 64'h33) $display("FAIL start_mtlo: got %h_%h expected 00000000_00000033", hi, lo); else passes++;
    checks++; if (lat !== 33) $display("FAIL start_mtlo_latency: got %0d expected 33", lat); else passes++;
  endtask

  task automatic test_async_reset();
    int lat, bcy;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; srcA = 32'hA5A5_A5A5;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk); start = 1'b1; oper = 2'd2; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL async_rst_done: got %b expected 0", done); else passes++;
    checks++; if ({hi, lo} !== 64'h0) $display("FAIL async_rst_hilo: got %h_%h expected 0_0", hi, lo); else passes++;
    @(negedge clk); rst_n = 1'b1;
    do_op(2'd0, 32'd6, 32'd7, lat, bcy);
    checks++; if ({hi, lo} !== 64'd42) $display("FAIL post_reset_mult: got %h_%h expected 00000000_0000002a", hi, lo); else passes++;
    checks++; if (lat !== 33) $display("FAIL post_reset_latency: got %0d expected 33", lat); else passes++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; oper = 2'd0; srcA = '0; srcB = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_directed();
    test_random();
    test_moves();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
- Iterative multiply/divide unit with HI/LO result registers, for MIPS MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside sm_alu in the CPU datapath; the CPU holds the PC while busy=1.
- Parametrised in operand width and carries internal state, unlike the single-cycle ALU.
- One shift-add (or shift-subtract) step per clock; sign correction is a final cycle.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; minimum 4.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request an operation; sampled only in IDLE
oper  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
srcA  input  WIDTH  multiplicand / dividend (rs)
srcB  input  WIDTH  multiplier / divisor (rt)
mthi  input  1  write srcA into hi
mtlo  input  1  write srcA into lo
busy  output  1  operation in progress; CPU stalls while high
done  output  1  one-cycle pulse, hi/lo just updated by an operation
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers cleared.
  - Takes effect mid-operation: the operation is abandoned with no partial result.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at an edge: latch oper, srcA, srcB.
  - Signed ops: latch operand magnitudes and the result signs. Product/quotient sign = A[WIDTH-1]^B[WIDTH-1]; remainder sign = A[WIDTH-1].
  - Counter=WIDTH, busy=1 after the edge, go to CALC.
- CALC:
  - One radix-2 step per cycle; counter decrements; go to FIX on the edge where counter reaches 0.
  - Multiply: 2*WIDTH-bit accumulator, conditional add of the multiplicand, right shift.
  - Divide: restoring division; the partial remainder is WIDTH+1 bits wide.
- FIX:
  - Negate results as required by the latched signs; write hi/lo.
  - done=1 for exactly this following cycle; busy=0 from the same edge; return to IDLE.
- Latency:
  - Accepting edge E0; hi/lo valid and done=1 after edge E0+WIDTH+1.
  - busy=1 for WIDTH+1 cycles.
  - A new start may be accepted in the cycle done=1.
- Arithmetic:
  - Products are exact 2*WIDTH-bit results.
  - Division truncates toward zero; remainder carries the dividend's sign.
  - Overflow case DIV MIN/-1: lo=MIN (0x80000000 for WIDTH=32), hi=0.
- Divide by zero (srcB=0, DIV or DIVU):
  - Still takes full latency.
  - Result forced to lo = all ones, hi = srcA as latched, for either signedness.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; write hi/lo at the edge; done stays 0.
  - Both set together: both registers get srcA.
- Ignored inputs:
  - start, mthi and mtlo are ignored while busy=1.
  - start together with mthi or mtlo: start wins and the moves are discarded.
- Holding: hi/lo hold their value during CALC, so MFHI/MFLO read the old values until done.
- oper is sampled only at acceptance; later changes have no effect.

Test Plan:
- MULT srcA=0xFFFFFFFD (-3), srcB=5 -> done after 33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU srcA=srcB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULTU 0x10000*0x10000 -> hi=1, lo=0.
- DIVU 100/7 -> lo=0xE, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0xFFFFFFF9/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9 after full latency.
- Idle mthi with srcA=0x12345678, then mtlo with 0x9ABCDEF0 -> hi/lo updated next edge, done=0. mthi pulsed during a busy MULTU -> ignored, final hi is the product. start+mtlo together -> operation runs, lo is not written by the move.
- Assert rst_n=0 asynchronously 10 cycles into DIVU -> busy, done, hi, lo read 0 immediately. After release, a fresh MULTU 6*7 -> lo=42, hi=0.
